// File: rtl/global_pkg.sv
// ============================================================================
// Module   : global_pkg
// Brief    : Shared types and constants for the program-memory boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package global_pkg;

  localparam int LOADER_LEN_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } loader_state_t;

  function automatic int bytes_per_word(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_mem_array.sv
// ============================================================================
// Module   : prog_mem_array
// Brief    : DEPTH x DATA_W storage, synchronous write, combinational read that
//            returns zero for addresses beyond DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_array #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              Clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Contents deliberately carry no reset: an image survives a loader reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  if (DEPTH < (1 << ADDR_W)) begin : g_partial
    assign rd_data = ({{(32-ADDR_W){1'b0}}, rd_addr} < 32'(DEPTH)) ? r_mem[rd_addr] : '0;
  end else begin : g_full
    assign rd_data = r_mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/prog_mem_loader.sv
// ============================================================================
// Module   : prog_mem_loader
// Brief    : Program memory with serial boot loader; holds the CPU in reset
//            until a length-prefixed image is loaded. Define
//            PROG_MEM_CHECKSUM_EN to require a trailing 8-bit checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_loader
  import global_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Load_Start,
  input  logic              Rx_Valid,
  input  logic [7:0]        Rx_Data,
  input  logic [ADDR_W-1:0] ROM_Addr,
  output logic [DATA_W-1:0] ROM_Data,
  output logic              Cpu_Rst_n,
  output logic              Load_Busy,
  output logic              Load_Done,
  output logic              Load_Err
);

  localparam int             BPW         = bytes_per_word(DATA_W);
  localparam int             BCW         = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] c_last_byte = BCW'(BPW - 1);
  localparam int             CNT_W       = 17;

  loader_state_t     r_state;
  logic [ADDR_W:0]   r_addr;
  logic [BCW-1:0]    r_byte_cnt;
  logic [15:0]       r_len;
  logic [7:0]        r_len_hi;
`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0]        r_sum;
`endif

  logic [15:0]       w_len;
  logic              w_word_last;
  logic              w_last_word;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_word;

  assign w_len       = {r_len_hi, Rx_Data};
  assign w_word_last = (r_byte_cnt == c_last_byte);
  assign w_last_word = (CNT_W'(r_addr) + CNT_W'(1)) == {1'b0, r_len};
  assign w_wr_en     = (r_state == DATA) && Rx_Valid && w_word_last;

  // Only the bits that survive truncation to DATA_W are kept from the high byte.
  if (DATA_W > 8) begin : g_pair
    logic [DATA_W-9:0] r_hi;
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        r_hi <= '0;
      end else if ((r_state == DATA) && Rx_Valid && !w_word_last) begin
        r_hi <= Rx_Data[DATA_W-9:0];
      end
    end
    assign w_word = {r_hi, Rx_Data};
  end else begin : g_single
    assign w_word = Rx_Data[DATA_W-1:0];
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_byte_cnt <= '0;
      r_len      <= '0;
      r_len_hi   <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
      r_sum      <= '0;
`endif
      Cpu_Rst_n  <= 1'b0;
      Load_Busy  <= 1'b0;
      Load_Done  <= 1'b0;
      Load_Err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (Load_Start) begin
            r_state    <= LEN_HI;
            r_addr     <= '0;
            r_byte_cnt <= '0;
`ifdef PROG_MEM_CHECKSUM_EN
            r_sum      <= '0;
`endif
            Cpu_Rst_n  <= 1'b0;
            Load_Busy  <= 1'b1;
            Load_Done  <= 1'b0;
            Load_Err   <= 1'b0;
          end
        end
        LEN_HI: begin
          if (Rx_Valid) begin
            r_len_hi <= Rx_Data;
            r_state  <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (Rx_Valid) begin
            r_len <= w_len;
            if (w_len == 16'd0) begin
`ifdef PROG_MEM_CHECKSUM_EN
              r_state   <= CHK;
`else
              r_state   <= DONE;
              Load_Busy <= 1'b0;
              Load_Done <= 1'b1;
              Cpu_Rst_n <= 1'b1;
`endif
            end else if ({16'd0, w_len} > 32'(DEPTH)) begin
              r_state   <= ERROR;
              Load_Busy <= 1'b0;
              Load_Err  <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (Rx_Valid) begin
`ifdef PROG_MEM_CHECKSUM_EN
            r_sum <= r_sum + Rx_Data;
`endif
            if (w_word_last) begin
              r_byte_cnt <= '0;
              r_addr     <= r_addr + 1'b1;
              if (w_last_word) begin
`ifdef PROG_MEM_CHECKSUM_EN
                r_state   <= CHK;
`else
                r_state   <= DONE;
                Load_Busy <= 1'b0;
                Load_Done <= 1'b1;
                Cpu_Rst_n <= 1'b1;
`endif
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 1'b1;
            end
          end
        end
`ifdef PROG_MEM_CHECKSUM_EN
        CHK: begin
          if (Rx_Valid) begin
            Load_Busy <= 1'b0;
            if (8'(r_sum + Rx_Data) == 8'd0) begin
              r_state   <= DONE;
              Load_Done <= 1'b1;
              Cpu_Rst_n <= 1'b1;
            end else begin
              r_state  <= ERROR;
              Load_Err <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= IDLE;
          Cpu_Rst_n <= 1'b0;
          Load_Busy <= 1'b0;
          Load_Done <= 1'b0;
          Load_Err  <= 1'b0;
        end
      endcase
    end
  end

  prog_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .Clk     (Clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_addr[ADDR_W-1:0]),
    .wr_data (w_word),
    .rd_addr (ROM_Addr),
    .rd_data (ROM_Data)
  );

endmodule

`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
// ============================================================================
// Module   : tb_prog_mem_loader
// Brief    : Scoreboard bench for prog_mem_loader; build with or without
//            PROG_MEM_CHECKSUM_EN to match the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_mem_loader;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam int BPW    = (DATA_W + 7) / 8;
`ifdef PROG_MEM_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Load_Start = 1'b0;
  logic              Rx_Valid = 1'b0;
  logic [7:0]        Rx_Data = 8'd0;
  logic [ADDR_W-1:0] ROM_Addr = '0;
  logic [DATA_W-1:0] ROM_Data;
  logic              Cpu_Rst_n;
  logic              Load_Busy;
  logic              Load_Done;
  logic              Load_Err;

  prog_mem_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Load_Start(Load_Start), .Rx_Valid(Rx_Valid),
    .Rx_Data(Rx_Data), .ROM_Addr(ROM_Addr), .ROM_Data(ROM_Data),
    .Cpu_Rst_n(Cpu_Rst_n), .Load_Busy(Load_Busy), .Load_Done(Load_Done),
    .Load_Err(Load_Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_rom;
    int          addr;
    logic [15:0] exp;
    string       name;
  } item_t;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  // Reference image: what the memory must hold, from the stream rules alone.
  logic [DATA_W-1:0] ref_mem   [DEPTH];
  bit                ref_known [DEPTH];
  int                stream[$];

  // Monitor: compares each expectation in the cycle it was issued for.
  item_t       mon_it;
  logic [15:0] mon_act;
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_it = sbq.pop_front();
      if (mon_it.is_rom) begin
        ROM_Addr = ADDR_W'(mon_it.addr);
        #1;
        mon_act = 16'(ROM_Data);
      end else begin
        mon_act = {12'd0, Load_Busy, Load_Done, Load_Err, Cpu_Rst_n};
      end
      checks++;
      if (mon_act !== mon_it.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                 mon_it.name, mon_act, mon_it.exp, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Status expectation packed as {busy, done, err, cpu_rst_n}.
  task automatic push_status(input string nm, input bit b, input bit d, input bit e, input bit c);
    item_t it;
    it.cyc = cyc; it.is_rom = 1'b0; it.addr = 0;
    it.exp = {12'd0, b, d, e, c}; it.name = nm;
    sbq.push_back(it);
  endtask

  task automatic push_rom(input string nm, input int a);
    item_t it;
    it.cyc = cyc; it.is_rom = 1'b1; it.addr = a;
    it.exp = 16'(ref_mem[a]); it.name = nm;
    sbq.push_back(it);
    tick();
  endtask

  task automatic send_byte(input int b);
    Rx_Valid = 1'b1;
    Rx_Data  = b[7:0];
    tick();
    Rx_Valid = 1'b0;
  endtask

  task automatic pulse_start();
    Load_Start = 1'b1;
    tick();
    Load_Start = 1'b0;
  endtask

  task automatic send_range(input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      send_byte(stream[i]);
    end
  endtask

  task automatic add_chk(input bit bad);
    int s = 0;
    for (int i = 2; i < stream.size(); i++) s += stream[i];
    if (CHK_EN) begin
      if (bad) stream.push_back((256 - (s % 256) + 1 + $urandom_range(0, 254)) % 256);
      else     stream.push_back((256 - (s % 256)) % 256);
    end
  endtask

  task automatic build_stream(input int n, input bit bad);
    stream.delete();
    stream.push_back((n >> 8) & 255);
    stream.push_back(n & 255);
    for (int i = 0; i < n * BPW; i++) stream.push_back($urandom_range(0, 255));
    add_chk(bad);
  endtask

  // Interpret the first nsent bytes of the stream: update the image, give the outcome.
  task automatic model(input int nsent, output bit done, output bit err);
    int n, sum, w;
    done = 1'b0; err = 1'b0;
    if (nsent < 2) return;
    n = stream[0] * 256 + stream[1];
    if (n > DEPTH) begin
      err = 1'b1;
      return;
    end
    sum = 0;
    for (int i = 0; i < n; i++) begin
      if (2 + BPW * (i + 1) > nsent) return;
      w = 0;
      for (int j = 0; j < BPW; j++) begin
        w = w * 256 + stream[2 + BPW * i + j];
        sum += stream[2 + BPW * i + j];
      end
      w = w % (1 << DATA_W);
      ref_mem[i]   = w[DATA_W-1:0];
      ref_known[i] = 1'b1;
    end
    if (CHK_EN) begin
      if (nsent < 3 + BPW * n) return;
      done = ((sum + stream[2 + BPW * n]) % 256) == 0;
      err  = !done;
    end else begin
      done = 1'b1;
    end
  endtask

  task automatic fixed_stream(input bit bad_chk);
    stream.delete();
    stream = '{8'h00, 8'h02, 8'h0A, 8'h01, 8'h01, 8'h02};
    add_chk(bad_chk);
  endtask

  initial begin
    bit d, e;
    int n, a;

    repeat (3) tick();
    Rst_n = 1'b1;
    push_status("reset_state", 0, 0, 0, 0);
    tick();

    // Two-word image with a good checksum
    fixed_stream(1'b0);
    pulse_start();
    push_status("start_busy", 1, 0, 0, 0);
    send_range(0, stream.size(), 1'b0);
    model(stream.size(), d, e);
    push_status("load1_done", 0, d, e, d);
    tick();
    push_rom("load1_word0", 0);
    push_rom("load1_word1", 1);

`ifdef PROG_MEM_CHECKSUM_EN
    // Same image, bad checksum: error with data already written
    fixed_stream(1'b1);
    stream[stream.size()-1] = 0;
    pulse_start();
    send_range(0, stream.size(), 1'b1);
    model(stream.size(), d, e);
    push_status("bad_chk_err", 0, d, e, d);
    tick();
    push_rom("bad_chk_word0", 0);
`endif

    // Length above DEPTH: error right after the low length byte
    stream.delete();
    stream = '{8'h10, 8'h01};
    pulse_start();
    push_status("restart_busy", 1, 0, 0, 0);
    send_range(0, 2, 1'b0);
    model(2, d, e);
    push_status("oversize_err", 0, d, e, d);
    tick();
    push_rom("oversize_keep0", 0);
    push_rom("oversize_keep1", 1);

    // Empty image keeps previous contents
    stream.delete();
    stream = '{8'h00, 8'h00};
    add_chk(1'b0);
    pulse_start();
    send_range(0, stream.size(), 1'b0);
    model(stream.size(), d, e);
    push_status("empty_done", 0, d, e, d);
    tick();
    push_rom("empty_keep0", 0);

    // Async reset after three data bytes; only the completed word lands
    fixed_stream(1'b0);
    stream[2] = 8'h05; stream[3] = 8'h5A; stream[4] = 8'h07;
    pulse_start();
    send_range(0, 5, 1'b0);
    model(5, d, e);
    Rst_n = 1'b0;
    #1;
    push_status("async_rst", 0, 0, 0, 0);
    tick();
    Rst_n = 1'b1;
    tick();
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h33);
    push_status("idle_ignores_rx", 0, 0, 0, 0);
    tick();
    push_rom("rst_partial_word0", 0);
    push_rom("rst_untouched_word1", 1);

    // Mid-load Load_Start is ignored
    build_stream(2, 1'b0);
    pulse_start();
    send_range(0, 4, 1'b0);
    pulse_start();
    push_status("midload_start_ignored", 1, 0, 0, 0);
    send_range(4, stream.size(), 1'b0);
    model(stream.size(), d, e);
    push_status("midload_done", 0, d, e, d);
    tick();
    push_rom("midload_word1", 1);

    // Load_Start with a coincident byte while in DONE
    Load_Start = 1'b1; Rx_Valid = 1'b1; Rx_Data = 8'h00;
    tick();
    Load_Start = 1'b0; Rx_Valid = 1'b0;
    push_status("done_restart_cpu_low", 1, 0, 0, 0);
    stream.delete();
    stream = '{8'h00, 8'h01, 8'hAB, 8'hCD};
    add_chk(1'b0);
    send_range(0, 2, 1'b0);
    push_status("coincident_byte_dropped", 1, 0, 0, 0);
    send_range(2, stream.size(), 1'b0);
    model(stream.size(), d, e);
    push_status("coincident_done", 0, d, e, d);
    tick();
    push_rom("coincident_word0", 0);

    // Full-depth image: address counter must not wrap
    build_stream(DEPTH, 1'b0);
    pulse_start();
    send_range(0, stream.size(), 1'b0);
    model(stream.size(), d, e);
    push_status("full_depth_done", 0, d, e, d);
    tick();
    push_rom("full_depth_first", 0);
    push_rom("full_depth_last", DEPTH - 1);

    // Randomized loads
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        n = DEPTH + 1 + $urandom_range(0, 1000);
        stream.delete();
        stream.push_back((n >> 8) & 255);
        stream.push_back(n & 255);
      end else begin
        n = $urandom_range(1, 6);
        build_stream(n, $urandom_range(0, 3) == 0);
      end
      pulse_start();
      push_status("rnd_start", 1, 0, 0, 0);
      send_range(0, stream.size(), 1'b1);
      model(stream.size(), d, e);
      push_status("rnd_end", 0, d, e, d);
      tick();
      for (int r = 0; r < 2; r++) begin
        a = $urandom_range(0, 7);
        push_rom("rnd_rom", a);
      end
    end

    for (int k = 0; k < 20 && sbq.size() > 0; k++) tick();
    if (sbq.size() > 0) begin
      errors += sbq.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/prog_mem_loader.md
# prog_mem_loader

Parametrised program memory with serial boot loader. Replaces the fixed-content instruction ROM that feeds the microcontroller. Receives a length-prefixed byte stream from the UART receiver, packs the bytes into DATA_W-bit instruction words and writes them from address 0 upward. Holds the CPU in reset until a complete image is loaded, then serves instruction fetches on ROM_Addr/ROM_Data.

## Interface
- DATA_W, 12: instruction word width; 1..16.
- ADDR_W, 12: fetch address width; 1..16.
- DEPTH, 4096: number of words; must satisfy DEPTH ≤ 2^ADDR_W.
- Clk  in  1: single clock, rising edge.
- Rst_n  in  1: asynchronous, active-low reset.
- Load_Start  in  1: one-cycle pulse; begins a load.
- Rx_Valid  in  1: one-cycle strobe; Rx_Data is valid. There is no backpressure; every strobe is consumed.
- Rx_Data  in  8: received byte.
- ROM_Addr  in  ADDR_W: fetch address.
- ROM_Data  out  DATA_W: fetched word.
- Cpu_Rst_n  out  1: active-low reset to the CPU.
- Load_Busy  out  1: a load is in progress.
- Load_Done  out  1: the last load completed successfully.
- Load_Err  out  1: the last load failed.

## Operation
- Byte stream: LEN_HI, LEN_LO, N words, then an optional CHK byte.
  - N is a 16-bit big-endian word count.
  - Each word is BPW = ceil(DATA_W/8) bytes, big-endian.
  - The word is taken from the low DATA_W bits of the assembled bytes; upper bits are discarded.
- FSM states:
  - IDLE: on Load_Start, go to LEN_HI.
  - LEN_HI: on Rx_Valid, go to LEN_LO.
  - LEN_LO: on Rx_Valid:
    - N=0: go to CHK if checksum is enabled, otherwise DONE.
    - N>DEPTH: go to ERROR.
    - otherwise: go to DATA.
  - DATA: count bytes. On the BPW-th byte of a word, write the word at the current address and increment the address. After word N, go to CHK or DONE.
  - CHK: on Rx_Valid, go to DONE or ERROR.
  - DONE and ERROR: on Load_Start, go to LEN_HI.
- Outputs by state:
  - Load_Busy = 1 in LEN_HI, LEN_LO, DATA, CHK.
  - Load_Done = 1 only in DONE.
  - Load_Err = 1 only in ERROR.
  - Cpu_Rst_n = 1 only in DONE; it is 0 in every other state.
- Rx_Valid is ignored in IDLE, DONE and ERROR.
- Load_Start is ignored while Load_Busy=1.
- If Load_Start and Rx_Valid arrive in the same cycle in IDLE/DONE/ERROR, the byte is dropped and the FSM enters LEN_HI.
- Words at addresses ≥ N keep their previous contents; the memory is never cleared.
- Address counter is ADDR_W+1 bits, so N=DEPTH=2^ADDR_W does not wrap.
- Read port: ROM_Data = mem[ROM_Addr], combinational, matching the existing CPU fetch timing.
  - ROM_Addr ≥ DEPTH returns all-zero.
  - Reads during a load return the current contents.

## Timing
- Reset values:
  - FSM in IDLE; address and byte counters 0.
  - Cpu_Rst_n=0, Load_Busy=0, Load_Done=0, Load_Err=0.
  - Memory contents are not reset.
- Load_Start at edge k: Load_Busy=1 after edge k. Cpu_Rst_n falls after edge k if the FSM was in DONE.
- Word write: the word is written at the same edge that samples its final byte, and is readable immediately after that edge.
- Completion: Load_Done=1 and Cpu_Rst_n=1 are registered one edge after the final stream byte is sampled.
- Async reset mid-load: return to IDLE immediately; partially written words remain in memory.

## Configuration
- PROG_MEM_CHECKSUM_EN defined:
  - An 8-bit running sum of all data bytes is kept; the length bytes are excluded.
  - A trailing CHK byte is required. Sum + CHK ≡ 0 mod 256 goes to DONE; any other value goes to ERROR.
  - Data words are already written when ERROR is entered.
- Not defined:
  - The CHK state and the sum register are absent.
  - The FSM enters DONE directly after word N (or after LEN_LO when N=0).

## Structure
- global_pkg gains:
  - loader_state_t enum: IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERROR.
  - localparam LOADER_LEN_BYTES = 2.
- Sub-module prog_mem_array: DEPTH×DATA_W array, one synchronous write port, one combinational read port with out-of-range zeroing.
- The FSM, counters, word packing and checksum live in prog_mem_loader.

## Test plan
1. Defaults, checksum enabled. Reset, then Load_Start, then bytes 00 02 0A 01 01 02, then CHK F2.
   - Load_Done=1 and Cpu_Rst_n=1.
   - ROM_Addr=0 reads 0xA01; ROM_Addr=1 reads 0x102.
2. Same stream with CHK 00.
   - Load_Err=1 and Cpu_Rst_n stays 0.
   - Address 0 still reads 0xA01.
   - A new Load_Start re-enters Load_Busy.
3. Length 0x1001 (4097 > DEPTH).
   - Load_Err=1 one edge after LEN_LO is sampled.
   - Memory is unchanged.
4. N=0, then CHK 00.
   - Load_Done=1 with no writes.
   - A prior image at address 0 is preserved.
5. Pulse Rst_n low after 3 data bytes.
   - All status outputs are 0 and the FSM is IDLE.
   - Address 0 holds the word already completed.
   - Rx_Valid strobes before the next Load_Start are ignored.
6. Load_Start pulsed mid-load, and Load_Start with Rx_Valid in the same cycle while in DONE.
   - The mid-load pulse is ignored.
   - In DONE, Cpu_Rst_n falls and the coincident byte is not taken as LEN_HI.
